// File: rtl/piece_bag_pkg.sv
// piece_bag shared types: piece IDs, full-bag mask, FSM encoding.
// Used by piece_bag and piece_queue.
package piece_bag_pkg;

  localparam logic [2:0] PIECE_I = 3'd0;
  localparam logic [2:0] PIECE_O = 3'd1;
  localparam logic [2:0] PIECE_T = 3'd2;
  localparam logic [2:0] PIECE_S = 3'd3;
  localparam logic [2:0] PIECE_Z = 3'd4;
  localparam logic [2:0] PIECE_J = 3'd5;
  localparam logic [2:0] PIECE_L = 3'd6;

  localparam logic [6:0] BAG_FULL = 7'h7F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_e;

  function automatic logic [2:0] lowest_set(
    input logic [6:0] m
  );
    logic [2:0] r;
    priority casez (m)
      7'b??????1: r = PIECE_I;
      7'b?????10: r = PIECE_O;
      7'b????100: r = PIECE_T;
      7'b???1000: r = PIECE_S;
      7'b??10000: r = PIECE_Z;
      7'b?100000: r = PIECE_J;
      7'b1000000: r = PIECE_L;
      default:    r = PIECE_I;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/piece_queue.sv
// Shift-register preview FIFO of 3-bit piece IDs.
// Head at entry 0; a pop with push lands the new entry at count-1.
module piece_queue #(
  parameter int DEPTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [2:0]         din_i,
  output logic [2:0]         count_o,
  output logic [2:0]         count_nx_o,
  output logic [3*DEPTH-1:0] data_o
);

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  logic [2:0] ent_q [DEPTH];
  logic [2:0] ent_d [DEPTH];
  logic [2:0] cnt_q;
  logic [2:0] cnt_d;
  logic [2:0] pos;
  logic       do_pop;
  logic       do_push;

  always_comb begin
    do_pop  = pop_i && (cnt_q != 3'd0);
    do_push = push_i && ((cnt_q < DEPTH_C) || do_pop);
    pos     = cnt_q - {2'b0, do_pop};
    for (int k = 0; k < DEPTH; k++) ent_d[k] = ent_q[k];
    if (do_pop) begin
      for (int k = 0; k < DEPTH - 1; k++) ent_d[k] = ent_q[k+1];
      ent_d[DEPTH-1] = '0;
    end
    if (do_push) begin
      for (int k = 0; k < DEPTH; k++)
        if (pos == 3'(k)) ent_d[k] = din_i;
    end
    cnt_d = cnt_q + {2'b0, do_push} - {2'b0, do_pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) ent_q[k] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int k = 0; k < DEPTH; k++) ent_q[k] <= ent_d[k];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_out
    assign data_o[3*k +: 3] = ent_q[k];
  end

  assign count_o    = cnt_q;
  assign count_nx_o = cnt_d;

endmodule

// File: rtl/piece_bag.sv
// 7-bag tetromino generator fed by an LFSR, with preview queue.
// Optional PIECE_BAG_STATS_EN adds bag_count and reject_total.
module piece_bag
  import piece_bag_pkg::*;
#(
  parameter int NEXT_DEPTH = 3,
  parameter int MAX_REJECT = 15,
  parameter int RND_W      = 13
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [RND_W-1:0]        rnd,
  output logic                    rnd_en,
  input  logic                    take,
  output logic [2:0]              piece,
  output logic                    piece_valid,
  output logic [3*NEXT_DEPTH-1:0] preview,
  output logic [2:0]              q_count
`ifdef PIECE_BAG_STATS_EN
  ,
  output logic [7:0]              bag_count,
  output logic [15:0]             reject_total
`endif
);

  localparam int RW = $clog2(MAX_REJECT + 1);
  localparam logic [RW-1:0] REJ_MAX = RW'(MAX_REJECT);
  localparam logic [2:0] DEPTH_C = 3'(NEXT_DEPTH);

  state_e        state_q;
  logic          rnd_en_q;
  logic [6:0]    mask_q, mask_d;
  logic [RW-1:0] rej_q, rej_d;
  logic [7:0]    mask8;
  logic [6:0]    cleared;
  logic [2:0]    idx, pid, cnt_nx;
  logic          fill, accept, fallback, push, reload;
  logic          unused_rnd;

  assign unused_rnd = ^{rnd[RND_W-1:11], rnd[7:3]};

  always_comb begin
    idx      = rnd[2:0] ^ rnd[10:8];
    mask8    = {1'b0, mask_q};
    fill     = (state_q == FILL);
    accept   = mask8[idx];
    fallback = (rej_q == REJ_MAX);
    push     = fill && (fallback || accept);
    pid      = fallback ? lowest_set(mask_q) : idx;
    cleared  = mask_q & ~(7'b1 << pid);
    reload   = push && (cleared == 7'b0);
    mask_d   = mask_q;
    rej_d    = rej_q;
    if (push) begin
      mask_d = reload ? BAG_FULL : cleared;
      rej_d  = '0;
    end else if (fill) begin
      rej_d  = rej_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rnd_en_q <= 1'b0;
      mask_q   <= BAG_FULL;
      rej_q    <= '0;
    end else begin
      mask_q <= mask_d;
      rej_q  <= rej_d;
      unique case (state_q)
        IDLE: begin
          state_q  <= FILL;
          rnd_en_q <= 1'b1;
        end
        FILL, FULL: begin
          if (cnt_nx == DEPTH_C) begin
            state_q  <= FULL;
            rnd_en_q <= 1'b0;
          end else begin
            state_q  <= FILL;
            rnd_en_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          rnd_en_q <= 1'b0;
        end
      endcase
    end
  end

  piece_queue #(
    .DEPTH (NEXT_DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .pop_i      (take),
    .din_i      (pid),
    .count_o    (q_count),
    .count_nx_o (cnt_nx),
    .data_o     (preview)
  );

  assign rnd_en      = rnd_en_q;
  assign piece       = preview[2:0];
  assign piece_valid = (q_count != 3'd0);

`ifdef PIECE_BAG_STATS_EN
  logic [7:0]  bag_q;
  logic [15:0] rtot_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bag_q  <= '0;
      rtot_q <= '0;
    end else begin
      if (reload) bag_q <= bag_q + 8'd1;
      if (fill && !push && rtot_q != 16'hFFFF)
        rtot_q <= rtot_q + 16'd1;
    end
  end

  assign bag_count    = bag_q;
  assign reject_total = rtot_q;
`endif

endmodule

// File: tb/tb_piece_bag.sv
// Directed self-checking bench for piece_bag.
// Stats ports are connected and checked when PIECE_BAG_STATS_EN is set.
module tb_piece_bag;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] rnd;
  logic        rnd_en;
  logic        take;
  logic [2:0]  piece;
  logic        piece_valid;
  logic [8:0]  preview;
  logic [2:0]  q_count;
`ifdef PIECE_BAG_STATS_EN
  logic [7:0]  bag_count;
  logic [15:0] reject_total;
`endif

  int checks = 0;
  int errors = 0;

  piece_bag dut (
    .clk         (clk),
    .rst         (rst),
    .rnd         (rnd),
    .rnd_en      (rnd_en),
    .take        (take),
    .piece       (piece),
    .piece_valid (piece_valid),
    .preview     (preview),
    .q_count     (q_count)
`ifdef PIECE_BAG_STATS_EN
    ,
    .bag_count    (bag_count),
    .reject_total (reject_total)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] ri(input int i);
    return 13'(i);
  endfunction

  task automatic reset_dut();
    rst  = 1'b1;
    take = 1'b0;
    tick();
    tick();
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (q_count !== 3'd0) begin
      errors++; $display("FAIL reset_count: got %0d exp 0", q_count);
    end
    checks++;
    if (piece_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %0b exp 0", piece_valid);
    end
    checks++;
    if (piece !== 3'd0) begin
      errors++; $display("FAIL reset_piece: got %0d exp 0", piece);
    end
    checks++;
    if (preview !== 9'h000) begin
      errors++; $display("FAIL reset_preview: got %0h exp 0", preview);
    end
    checks++;
    if (rnd_en !== 1'b0) begin
      errors++; $display("FAIL reset_rnd_en: got %0b exp 0", rnd_en);
    end
  endtask

  task automatic test_take_empty();
    take = 1'b1;
    rnd  = ri(0);
    tick();
    take = 1'b0;
    checks++;
    if (q_count !== 3'd0) begin
      errors++; $display("FAIL empty_take_count: got %0d exp 0", q_count);
    end
    checks++;
    if (piece_valid !== 1'b0) begin
      errors++; $display("FAIL empty_take_valid: got %0b exp 0", piece_valid);
    end
    checks++;
    if (rnd_en !== 1'b1) begin
      errors++; $display("FAIL fill_rnd_en: got %0b exp 1", rnd_en);
    end
  endtask

  task automatic test_fill();
    rnd = ri(0);
    tick();
    checks++;
    if (piece_valid !== 1'b1 || piece !== 3'd0) begin
      errors++;
      $display("FAIL fill_first: valid %0b piece %0d exp 1/0", piece_valid, piece);
    end
    rnd = ri(1);
    tick();
    checks++;
    if (q_count !== 3'd2 || rnd_en !== 1'b1) begin
      errors++;
      $display("FAIL fill_second: count %0d rnd_en %0b exp 2/1", q_count, rnd_en);
    end
    rnd = 13'h0507;
    tick();
    checks++;
    if (q_count !== 3'd3) begin
      errors++; $display("FAIL fill_count: got %0d exp 3", q_count);
    end
    checks++;
    if (preview !== 9'h088) begin
      errors++; $display("FAIL fill_preview: got %0h exp 088", preview);
    end
    checks++;
    if (rnd_en !== 1'b0) begin
      errors++; $display("FAIL full_rnd_en: got %0b exp 0", rnd_en);
    end
    rnd = ri(3);
    tick();
    checks++;
    if (q_count !== 3'd3 || preview !== 9'h088 || rnd_en !== 1'b0) begin
      errors++;
      $display("FAIL full_hold: count %0d prev %0h rnd_en %0b exp 3/088/0", q_count, preview, rnd_en);
    end
  endtask

  task automatic test_take_push();
    take = 1'b1;
    tick();
    checks++;
    if (q_count !== 3'd2 || piece !== 3'd1 || rnd_en !== 1'b1) begin
      errors++;
      $display("FAIL take_full: count %0d piece %0d rnd_en %0b exp 2/1/1", q_count, piece, rnd_en);
    end
    take = 1'b1;
    rnd  = ri(5);
    tick();
    take = 1'b0;
    checks++;
    if (q_count !== 3'd2) begin
      errors++; $display("FAIL tp_count: got %0d exp 2", q_count);
    end
    checks++;
    if (piece !== 3'd2 || preview !== 9'h02A) begin
      errors++;
      $display("FAIL tp_preview: piece %0d prev %0h exp 2/02a", piece, preview);
    end
    tick();
    checks++;
    if (q_count !== 3'd2) begin
      errors++; $display("FAIL tp_repeat_reject: got %0d exp 2", q_count);
    end
  endtask

  task automatic test_reject7();
    reset_dut();
    rnd = ri(7);
    tick();
    repeat (15) tick();
    checks++;
    if (q_count !== 3'd0) begin
      errors++; $display("FAIL rej7_before: got %0d exp 0", q_count);
    end
    tick();
    checks++;
    if (q_count !== 3'd1 || piece !== 3'd0) begin
      errors++;
      $display("FAIL rej7_fallback: count %0d piece %0d exp 1/0", q_count, piece);
    end
    repeat (4) tick();
    checks++;
    if (q_count !== 3'd1) begin
      errors++; $display("FAIL rej7_after: got %0d exp 1", q_count);
    end
`ifdef PIECE_BAG_STATS_EN
    checks++;
    if (reject_total !== 16'd19 || bag_count !== 8'd0) begin
      errors++;
      $display("FAIL rej7_stats: rt %0d bag %0d exp 19/0", reject_total, bag_count);
    end
`endif
  endtask

  task automatic test_fairness();
    logic [2:0] exp_seq [14] = '{3'd3, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6,
                                 3'd3, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
    logic [2:0] obs [14];
    logic [6:0] seen;
    int n = 0;
    reset_dut();
    rnd = ri(3);
    for (int c = 0; c < 280; c++) begin
      tick();
      if ((c % 4) == 3 && piece_valid && n < 14) begin
        obs[n] = piece;
        n++;
        take = 1'b1;
      end else begin
        take = 1'b0;
      end
    end
    take = 1'b0;
    checks++;
    if (n !== 14) begin
      errors++; $display("FAIL fair_count: got %0d exp 14", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs[i] !== exp_seq[i]) begin
        errors++;
        $display("FAIL fair_seq[%0d]: got %0d exp %0d", i, obs[i], exp_seq[i]);
      end
    end
    for (int g = 0; g + 7 <= n; g += 7) begin
      seen = 7'h00;
      for (int i = 0; i < 7; i++) seen[obs[g+i]] = 1'b1;
      checks++;
      if (seen !== 7'h7F) begin
        errors++; $display("FAIL fair_group%0d: got %0h exp 7f", g / 7, seen);
      end
    end
`ifdef PIECE_BAG_STATS_EN
    checks++;
    if (bag_count !== 8'd2) begin
      errors++; $display("FAIL fair_bags: got %0d exp 2", bag_count);
    end
`endif
  endtask

  task automatic test_mid_reset();
    reset_dut();
    tick();
    rnd = ri(0); tick();
    rnd = ri(1); tick();
    rnd = ri(5); tick();
    take = 1'b1; tick();
    take = 1'b0;
    rnd = ri(6); tick();
    take = 1'b1; tick();
    take = 1'b0;
    rnd = ri(0);
    checks++;
    if (q_count !== 3'd2 || preview !== 9'h035) begin
      errors++;
      $display("FAIL mr_setup: count %0d prev %0h exp 2/035", q_count, preview);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (piece_valid !== 1'b0 || q_count !== 3'd0 || rnd_en !== 1'b0) begin
      errors++;
      $display("FAIL mr_async: valid %0b count %0d rnd_en %0b exp 0/0/0", piece_valid, q_count, rnd_en);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    rnd = ri(0);
    tick();
    tick();
    checks++;
    if (q_count !== 3'd1 || piece !== 3'd0) begin
      errors++;
      $display("FAIL mr_mask0: count %0d piece %0d exp 1/0", q_count, piece);
    end
    rnd = ri(6);
    tick();
    checks++;
    if (q_count !== 3'd2 || preview !== 9'h030) begin
      errors++;
      $display("FAIL mr_mask6: count %0d prev %0h exp 2/030", q_count, preview);
    end
  endtask

  initial begin
    rst  = 1'b1;
    take = 1'b0;
    rnd  = '0;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    test_take_empty();
    test_fill();
    test_take_push();
    test_reject7();
    test_fairness();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piece_bag.md
Name: piece_bag

Overview:
- Consumer end of the LFSR random stream.
- Draws raw random words from the LFSR and turns them into a fair 7-bag sequence of tetromino IDs.
- Holds the IDs in a small preview queue that the game-control FSM pops with a one-cycle take pulse.
- Sits between the LFSR (drives its enable) and the game FSM / next-piece preview renderer.

Parameters:
- NEXT_DEPTH, 3, preview queue depth in entries (1..4).
- MAX_REJECT, 15, consecutive rejected draws before the deterministic fallback pick.
- RND_W, 13, width of the random word input.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- rnd  in  RND_W  current LFSR register value.
- rnd_en  out  1  advance request to the LFSR. The LFSR updates on the same edge.
- take  in  1  one-cycle pulse from the game FSM: consume the head piece.
- piece  out  3  head piece ID: 0=I, 1=O, 2=T, 3=S, 4=Z, 5=J, 6=L.
- piece_valid  out  1  head entry valid.
- preview  out  3*NEXT_DEPTH  queue contents. Entry k sits at bits [3k+2:3k]; entry 0 is the head.
- q_count  out  3  number of valid entries.

Behaviour:
- Reset (async, rst=1):
  - queue empty, q_count=0, piece_valid=0, piece=0, preview=0
  - mask=7'h7F (all seven pieces remaining), reject counter=0
  - rnd_en=0, FSM=IDLE
- FSM states:
  - IDLE: entered on reset release. Goes to FILL next cycle.
  - FILL: active whenever q_count<NEXT_DEPTH.
  - FULL: active when q_count==NEXT_DEPTH.
- Draw (evaluated every FILL cycle):
  - rnd_en=1 in every FILL cycle, so the sample is fresh each cycle.
  - idx = rnd[2:0] ^ rnd[10:8].
  - Accept if idx<7 and mask[idx]=1: push idx at the tail, clear mask[idx], reset the reject counter.
  - Otherwise reject and increment the reject counter.
  - If the reject counter == MAX_REJECT: push the lowest set mask bit instead, clear that bit, reset the counter.
- Bag refill: when the push clears the last mask bit, mask reloads to 7'h7F on the same edge.
- Latency:
  - At most one push per cycle.
  - The first piece_valid appears no earlier than 2 cycles after reset release (IDLE, then the first FILL draw).
  - The worst-case gap between pushes is MAX_REJECT+1 cycles.
- FULL state:
  - rnd_en=0 (the LFSR holds).
  - Moves back to FILL on the cycle after a take reduces the count.
- Take handling:
  - take with piece_valid=1: the queue shifts toward the head on that edge and q_count decrements.
  - take with piece_valid=0: ignored, no state change.
- Simultaneous take and push in the same cycle:
  - Both occur; q_count is unchanged.
  - The new entry lands at position q_count-1.
- Outputs are registered, with no combinational path from take to piece.
- Invalid preview slots read as 0.
- rst asserted mid-FILL: the queue and the partial bag are discarded; on release the block restarts at IDLE with a full mask.

Optional Feature:
- Macro PIECE_BAG_STATS_EN.
- When defined:
  - adds output bag_count [7:0], which increments (wrapping at 255) on each mask reload
  - adds output reject_total [15:0], which increments on every rejected draw and saturates at 16'hFFFF
  - both reset to 0
- When undefined: neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- Package piece_bag_pkg holds:
  - the piece ID localparams (PIECE_I..PIECE_L)
  - BAG_FULL=7'h7F
  - the FSM state encoding (IDLE, FILL, FULL)
- One sub-module, piece_queue: a shift-register FIFO of 3-bit entries, NEXT_DEPTH deep, with push/pop/count and the simultaneous push+pop rule.
- Draw/mask/reject logic stays in the parent.

Test Plan:
- Fill: release reset with rnd held so idx cycles 0,1,2; take=0.
  - Expect preview entries {0,1,2}, q_count=3.
  - Expect FULL state with rnd_en=0 from the cycle after the third push.
- Fairness: bench drives idx=3 constantly, with take pulsed every 4 cycles.
  - Expect 3 pushed first, then MAX_REJECT rejects, then fallback 0, 1, 2, 4, 5, 6 (lowest set bit each time).
  - Expect the mask to reload after 6; no ID repeats within any aligned group of 7.
- Reject 7: idx=7 for 20 cycles.
  - Expect fallback push of 0 after exactly 15 rejects.
- Take + push same cycle: queue at 2 entries in FILL, take pulsed coincident with an accepted draw of 5.
  - Expect q_count stays 2, the old entry 1 becomes the head, and 5 lands at entry 1.
- Take on empty: take pulsed during the IDLE cycle.
  - Expect no change; q_count=0.
- Mid-operation reset: rst asserted asynchronously with 2 entries held and mask=7'h1C.
  - Expect immediate piece_valid=0, q_count=0, rnd_en=0.
  - Expect mask 7'h7F after release.
